// File: rtl/delay_probe_pkg.sv
// Shared definitions for the delay_probe round-trip latency block:
// FSM state encoding and default probe/counter constants.
package delay_probe_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FLUSH  = 3'd1,
      SEND   = 3'd2,
      WAIT   = 3'd3,
      RESULT = 3'd4
   } state_t;

   localparam int         DEF_CNT_W    = 8;
   localparam logic [7:0] DEF_MARKER   = 8'hA5;
   localparam logic [7:0] DEF_IDLE_VAL = 8'h00;

endpackage

// File: rtl/delay_probe_if.sv
// Bundle of the delay_probe control, probe and result signals.
// Optional min/max statistics signals exist only when DELAY_PROBE_MINMAX_EN
// is defined.
interface delay_probe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);

   logic             start;
   logic [WIDTH-1:0] echo_in;
   logic [WIDTH-1:0] probe_out;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] delay_count;

`ifdef DELAY_PROBE_MINMAX_EN
   logic [CNT_W-1:0] min_delay;
   logic [CNT_W-1:0] max_delay;

   modport master (
      output start, output echo_in,
      input  probe_out, input busy, input done, input timeout, input delay_count,
      input  min_delay, input max_delay
   );

   modport slave (
      input  start, input echo_in,
      output probe_out, output busy, output done, output timeout, output delay_count,
      output min_delay, output max_delay
   );
`else
   modport master (
      output start, output echo_in,
      input  probe_out, input busy, input done, input timeout, input delay_count
   );

   modport slave (
      input  start, input echo_in,
      output probe_out, output busy, output done, output timeout, output delay_count
   );
`endif

endinterface

// File: rtl/delay_probe_counter.sv
// Loadable up-counter with a terminal-count flag. Used by delay_probe both
// for the flush interval and for counting cycles until the echo returns.
module delay_probe_counter #(
   parameter int CNT_W    = 8,
   parameter int TERMINAL = 127
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_term
);

   // Load takes priority over increment so a fresh interval always starts clean
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_term = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/delay_probe.sv
// delay_probe: launches one marker word into a delay line under test and
// reports how many clock cycles pass before it comes back on echo_in.
// Sequence: IDLE -> FLUSH (MAX_DELAY+1 cycles of idle words so no stale
// marker is left in the line) -> SEND (one marker word) -> WAIT -> RESULT.
// Optional feature macro: DELAY_PROBE_MINMAX_EN adds running min/max
// statistics over all non-timeout results.
module delay_probe
   import delay_probe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               MAX_DELAY = 127,
   parameter int               CNT_W     = DEF_CNT_W,
   parameter logic [WIDTH-1:0] MARKER    = WIDTH'(DEF_MARKER),
   parameter logic [WIDTH-1:0] IDLE_VAL  = WIDTH'(DEF_IDLE_VAL)
) (
   input logic          clock,
   input logic          reset,
   delay_probe_if.slave bus
);

   state_t           state;
   logic [WIDTH-1:0] probe_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] delay_q;

   logic             echo_hit;
   logic             flush_load;
   logic             flush_inc;
   logic             flush_term;
   logic [CNT_W-1:0] flush_cnt_unused;
   logic             cyc_load;
   logic             cyc_inc;
   logic             cyc_term;
   logic [CNT_W-1:0] cyc_cnt;

   assign echo_hit = (bus.echo_in == MARKER);

   // The flush interval restarts on every accepted start and stops at its terminal value
   assign flush_load = (state == IDLE) && bus.start;
   assign flush_inc  = (state == FLUSH) && !flush_term;

   // The cycle counter is 0 during SEND and only advances while nothing has matched and
   // the limit is not reached, so it can never exceed MAX_DELAY
   assign cyc_load = (state == FLUSH) && flush_term;
   assign cyc_inc  = ((state == SEND) && !echo_hit) ||
                     ((state == WAIT) && !echo_hit && !cyc_term);

   delay_probe_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (MAX_DELAY)
   ) flush_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (flush_load),
      .load_val ('0),
      .inc      (flush_inc),
      .count    (flush_cnt_unused),
      .at_term  (flush_term)
   );

   delay_probe_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (MAX_DELAY)
   ) cycle_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cyc_load),
      .load_val ('0),
      .inc      (cyc_inc),
      .count    (cyc_cnt),
      .at_term  (cyc_term)
   );

   // Measurement sequencer; every output is registered alongside the state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         probe_q   <= IDLE_VAL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         delay_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               probe_q <= IDLE_VAL;
               done_q  <= 1'b0;
               if (bus.start) begin
                  state     <= FLUSH;
                  busy_q    <= 1'b1;
                  timeout_q <= 1'b0;
                  delay_q   <= '0;
               end
            end
            FLUSH: begin
               if (flush_term) begin
                  state   <= SEND;
                  probe_q <= MARKER;
               end
            end
            SEND: begin
               probe_q <= IDLE_VAL;
               if (echo_hit) begin
                  delay_q <= '0;
                  state   <= RESULT;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               probe_q <= IDLE_VAL;
               if (echo_hit) begin
                  delay_q <= cyc_cnt;
                  state   <= RESULT;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (cyc_term) begin
                  timeout_q <= 1'b1;
                  delay_q   <= '1;
                  state     <= RESULT;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            RESULT: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state   <= IDLE;
               probe_q <= IDLE_VAL;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.probe_out   = probe_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.delay_count = delay_q;

`ifdef DELAY_PROBE_MINMAX_EN
   logic [CNT_W-1:0] min_q;
   logic [CNT_W-1:0] max_q;

   // Running statistics fold in each valid result while its done pulse is up
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         min_q <= '1;
         max_q <= '0;
      end else if ((state == RESULT) && !timeout_q) begin
         if (delay_q < min_q) begin
            min_q <= delay_q;
         end
         if (delay_q > max_q) begin
            max_q <= delay_q;
         end
      end
   end

   assign bus.min_delay = min_q;
   assign bus.max_delay = max_q;
`endif

endmodule

// File: doc/delay_probe.md
Name: delay_probe

Overview:
Round-trip latency measurement block for the delay-line family.
- Launches a single marker word into the data input of a delay line under test (probe_out) and watches that line's output (echo_in).
- Reports the number of clock cycles between launch and arrival.
- Sits beside the delay lines at the top level; it drives their data input and samples their selected output, so the configured delay is checked on silicon.

Parameters:
WIDTH, 8, data word width of probe_out/echo_in
MAX_DELAY, 127, largest measurable delay in cycles; also sets the flush length; must be < 2**CNT_W - 1
CNT_W, 8, width of cycle counter and delay_count
MARKER, 8'hA5, word launched as the probe; must differ from IDLE_VAL
IDLE_VAL, 8'h00, word driven on probe_out when not launching

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a measurement; sampled only in IDLE
echo_in  in  WIDTH  output of the delay line under test
probe_out  out  WIDTH  registered drive into the delay line data input
busy  out  1  high in FLUSH, SEND, WAIT
done  out  1  one-cycle pulse when a result is valid
timeout  out  1  sticky result flag: marker not seen within MAX_DELAY
delay_count  out  CNT_W  measured delay; held until next start

Behaviour:
- Reset (async, active-high) values: state=IDLE, probe_out=IDLE_VAL, busy=0, done=0, timeout=0, delay_count=0, counters=0.
- Reset asserted mid-operation aborts immediately with the same values; no partial result is reported.
- All outputs are registered.
- FSM states: IDLE, FLUSH, SEND, WAIT, RESULT.
- IDLE: probe_out=IDLE_VAL.
  - start=1 at a rising edge -> FLUSH.
  - The same edge clears timeout and delay_count and loads the flush counter with 0.
- FLUSH: probe_out=IDLE_VAL; echo_in ignored; lasts exactly MAX_DELAY+1 cycles, so any stale marker has left the line; then -> SEND.
- SEND: one cycle with probe_out=MARKER.
  - Cycle counter cnt=0 in this cycle.
  - If echo_in==MARKER in this cycle (zero-delay path): latch delay_count=0 -> RESULT.
  - Otherwise -> WAIT with cnt=1.
- WAIT: probe_out=IDLE_VAL.
  - Each cycle, if echo_in==MARKER: latch delay_count=cnt -> RESULT.
  - Else if cnt==MAX_DELAY: timeout=1, delay_count=all ones -> RESULT.
  - Else cnt increments.
  - A match in the same cycle as cnt==MAX_DELAY is a valid result (no timeout).
- Result from an N-register line: delay_count=N for N<=MAX_DELAY.
- RESULT: done=1 for exactly this one cycle, busy=0 -> IDLE.
  - delay_count and timeout hold until the next accepted start.
- start while busy or in RESULT: ignored; no queuing.
- start held high continuously: new measurement begins every MAX_DELAY+4+N cycles (back-to-back runs).
- Arithmetic: cnt is unsigned CNT_W bits, saturating by construction (never exceeds MAX_DELAY).
- echo_in compare is full WIDTH equality.

Optional Feature:
Macro DELAY_PROBE_MINMAX_EN.
- Defined: adds outputs min_delay and max_delay (CNT_W each).
  - Reset values: min_delay=all ones, max_delay=0.
  - Updated in RESULT when timeout=0: min = smaller of (min, delay_count); max = larger of (max, delay_count).
  - Cleared only by reset.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package delay_probe_pkg holds:
  - state enum constants (IDLE=0, FLUSH=1, SEND=2, WAIT=3, RESULT=4, 3-bit encoding);
  - default MARKER/IDLE_VAL constants;
  - CNT_W default.
- One natural sub-module: delay_probe_counter, a loadable up-counter with terminal-count compare, instanced for both flush and cycle counting.

Test Plan:
- probe_out looped through a 30-stage delay line, start pulse -> after 128 flush cycles one SEND, done pulse with delay_count=30, timeout=0.
- 90-stage line, MAX_DELAY=127 -> delay_count=90; 127-stage line -> delay_count=127, timeout=0.
- echo_in tied to 8'h00 -> done after exactly 128 WAIT/SEND cycles, timeout=1, delay_count=8'hFF.
- echo_in wired directly to probe_out -> delay_count=0, done in cycle after SEND.
- start pulsed again during WAIT -> ignored; single done, result unchanged. Then reset asserted mid-WAIT -> all outputs at reset values, no done.
- With DELAY_PROBE_MINMAX_EN: runs on 45- then 30- then 60-stage lines -> min_delay=30, max_delay=60; a timeout run leaves both unchanged.
